if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage directly upstream of the opcode decoder. Holds the PC and computes next-PC
//  (sequential / PC-relative / register). Fetches from a combinational instruction memory and
//  classifies the raw opcode into the 4-bit OPID. Registers {instr, pc, opid, valid} into the IF/ID
//  pipeline register that feeds the decoder.
// PARAMETERS
//  PC_W     64   width of PC and branch-register data
//  RESET_PC 0    PC value loaded on reset
// PORTS
//  clk            in   1      single clock, rising edge
//  reset          in   1      asynchronous, active-high reset
//  stall          in   1      hold PC and IF/ID register (hazard unit)
//  flush          in   1      squash IF/ID contents on next edge
//  br_taken       in   2      00 seq, 01 PC-relative, 10 register (BR); 11 treated as 00
//  uncond_br      in   1      1: offset = imm26, 0: offset = imm19 (PC-relative only)
//  imm19          in   19     signed word offset (B.cond / CBZ)
//  imm26          in   26     signed word offset (B / BL)
//  br_pc          in   PC_W   PC of the branching instruction (base for PC-relative target)
//  br_reg_data    in   PC_W   register value for BR target
//  imem_addr      out  PC_W   current PC to instruction memory
//  imem_rdata     in   32     instruction at imem_addr, same cycle
//  if_id_instr    out  32     registered instruction
//  if_id_pc       out  PC_W   registered PC of if_id_instr
//  if_id_opid     out  4      registered OPID class
//  if_id_valid    out  1      registered: IF/ID holds a real instruction
// BEHAVIOUR
//  - Reset (async, active-high): pc=RESET_PC; if_id_instr=0, if_id_pc=0, if_id_opid=4'b1111,
//    if_id_valid=0. Reset asserted mid-operation clears all state immediately, regardless of clock.
//  - imem_addr = pc (combinational). IF/ID captures imem_rdata/pc at the clock edge: 1-cycle latency.
//  - Next-PC priority per edge: redirect (br_taken 01/10) > stall > sequential.
//    01: pc <= br_pc + (sext(off) << 2), off = uncond_br ? imm26 : imm19, sign-extended to PC_W.
//    10: pc <= br_reg_data. 00/11: pc <= pc + 4. All arithmetic is modulo 2^PC_W (wraps, no trap).
//  - IF/ID update priority: redirect or flush > stall > load.
//    redirect/flush: instr=0, pc=0, opid=1111, valid=0 (wrong-path slot squashed).
//    stall (no redirect/flush): all IF/ID fields hold; pc holds.
//    load: instr=imem_rdata, pc=pc, opid=classify(imem_rdata), valid=1.
//  - Simultaneous stall+redirect: redirect wins (pc loads target, IF/ID squashed).
//    Simultaneous stall+flush without redirect: pc holds, IF/ID squashed.
//  - OPID classification on instr[31:21]; first match in this order:
//    ADDI 1001000100x -> 0000; ADDS 10101011000 -> 0001; B.cond 01010100xxx -> 0010;
//    B 000101xxxxx -> 0011; BL 100101xxxxx -> 0100; BR 11010110000 -> 0101;
//    CBZ 10110100xxx -> 0110; LDUR 11111000010 -> 0111; STUR 11111000000 -> 1000;
//    SUBS 11101011000 -> 1001; else 1111 (decoder drives all controls inactive).
//  - No branch prediction: pc+4 fetch continues until the decoder/branch logic redirects.
// STRUCTURE
//  - Shared package cpu_pkg: OPID localparams (OP_ADDI..OP_SUBS, OP_NOP=4'b1111), opcode bit patterns,
//    br_sel_e enum {BR_SEQ=2'b00, BR_REL=2'b01, BR_REG=2'b10}; the decoder imports the same constants.
//  - One sub-module: opid_classify (combinational instr[31:21] -> opid), reused by the testbench model.
//  - if_stage itself: PC register, next-PC mux/adders, IF/ID register with stall/flush.
// TESTING
//  1 Reset then release, imem returns ADDI 0x91000421 at every addr, 4 clocks -> imem_addr 0,4,8,12;
//    if_id_pc lags by one; opid=0000; valid=1 from the first edge after release.
//  2 br_taken=01, uncond_br=1, imm26=-2 (0x3FFFFFE), br_pc=0x40 -> pc=0x38 next edge; IF/ID valid=0,
//    opid=1111 for that cycle.
//  3 br_taken=01, uncond_br=0, imm19=0x00010, br_pc=0x100 -> pc=0x140. Then br_taken=10,
//    br_reg_data=0x1234 -> pc=0x1234.
//  4 stall=1 for 3 cycles at pc=0x20 -> imem_addr stays 0x20, IF/ID unchanged. stall=1 with
//    br_taken=10, br_reg_data=0x80 -> pc=0x80, IF/ID squashed.
//  5 pc=0xFFFF_FFFF_FFFF_FFFC, sequential -> pc wraps to 0. Encodings SUBS 0xEB020020 -> 1001,
//    LDUR 0xF8408020 -> 0111, BR 0xD61F03C0 -> 0101, 0x00000000 -> 1111.
//  6 Assert reset asynchronously between edges mid-fetch at pc=0x48 -> pc=0 and IF/ID cleared
//    immediately, before the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: OPID classes, opcode field width and branch-select encoding.
// Imported by the fetch stage, the classifier and the downstream decoder.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_W   = 11;

  localparam logic [3:0] OP_ADDI  = 4'b0000;
  localparam logic [3:0] OP_ADDS  = 4'b0001;
  localparam logic [3:0] OP_BCOND = 4'b0010;
  localparam logic [3:0] OP_B     = 4'b0011;
  localparam logic [3:0] OP_BL    = 4'b0100;
  localparam logic [3:0] OP_BR    = 4'b0101;
  localparam logic [3:0] OP_CBZ   = 4'b0110;
  localparam logic [3:0] OP_LDUR  = 4'b0111;
  localparam logic [3:0] OP_STUR  = 4'b1000;
  localparam logic [3:0] OP_SUBS  = 4'b1001;
  localparam logic [3:0] OP_NOP   = 4'b1111;

  typedef enum logic [1:0] {
    BR_SEQ = 2'b00,
    BR_REL = 2'b01,
    BR_REG = 2'b10
  } br_sel_e;

  // The unused 2'b11 encoding falls back to sequential fetch.
  function automatic br_sel_e decode_br(input logic [1:0] br_taken);
    case (br_taken)
      2'b01:   return BR_REL;
      2'b10:   return BR_REG;
      default: return BR_SEQ;
    endcase
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction-memory port plus the IF/ID pipeline register outputs.
interface if_stage_if import cpu_pkg::*; #(
  parameter int PC_W = 64
);

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] if_id_instr;
  logic [PC_W-1:0]    if_id_pc;
  logic [3:0]         if_id_opid;
  logic               if_id_valid;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output if_id_instr,
    output if_id_pc,
    output if_id_opid,
    output if_id_valid
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  if_id_instr,
    input  if_id_pc,
    input  if_id_opid,
    input  if_id_valid
  );

endinterface

// File: rtl/if_stage_classify.sv
// Combinational OPID classifier on instr[31:21]; first matching pattern wins.
module opid_classify import cpu_pkg::*; (
  input  logic [OPC_W-1:0] opcode,
  output logic [3:0]       opid
);

  always_comb begin
    opid = OP_NOP;
    casez (opcode)
      11'b1001000100?: opid = OP_ADDI;
      11'b10101011000: opid = OP_ADDS;
      11'b01010100???: opid = OP_BCOND;
      11'b000101?????: opid = OP_B;
      11'b100101?????: opid = OP_BL;
      11'b11010110000: opid = OP_BR;
      11'b10110100???: opid = OP_CBZ;
      11'b11111000010: opid = OP_LDUR;
      11'b11111000000: opid = OP_STUR;
      11'b11101011000: opid = OP_SUBS;
      default:         opid = OP_NOP;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, next-PC selection and the IF/ID pipeline register.
// No prediction; fetch runs sequentially until a redirect arrives from branch resolution.
module if_stage import cpu_pkg::*; #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [1:0]      br_taken,
  input  logic            uncond_br,
  input  logic [18:0]     imm19,
  input  logic [25:0]     imm26,
  input  logic [PC_W-1:0] br_pc,
  input  logic [PC_W-1:0] br_reg_data,
  if_stage_if.master      bus
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] offset;
  logic [PC_W-1:0] rel_target;
  logic [3:0]      fetch_opid;
  logic            redirect;
  logic            squash;
  br_sel_e         br_sel;

  opid_classify u_classify (
    .opcode (bus.imem_rdata[31:21]),
    .opid   (fetch_opid)
  );

  assign bus.imem_addr = pc;

  // Word offsets are sign-extended to full width, so targets wrap modulo 2^PC_W.
  always_comb begin
    br_sel     = decode_br(br_taken);
    redirect   = (br_sel != BR_SEQ);
    squash     = redirect | flush;
    offset     = uncond_br ? {{(PC_W-26){imm26[25]}}, imm26}
                           : {{(PC_W-19){imm19[18]}}, imm19};
    rel_target = br_pc + (offset << 2);
    pc_next    = pc;
    case (br_sel)
      BR_REL:  pc_next = rel_target;
      BR_REG:  pc_next = br_reg_data;
      default: pc_next = stall ? pc : pc + PC_W'(4);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // A redirect or flush squashes the wrong-path slot even while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.if_id_instr <= '0;
      bus.if_id_pc    <= '0;
      bus.if_id_opid  <= OP_NOP;
      bus.if_id_valid <= 1'b0;
    end else if (squash) begin
      bus.if_id_instr <= '0;
      bus.if_id_pc    <= '0;
      bus.if_id_opid  <= OP_NOP;
      bus.if_id_valid <= 1'b0;
    end else if (!stall) begin
      bus.if_id_instr <= bus.imem_rdata;
      bus.if_id_pc    <= pc;
      bus.if_id_opid  <= fetch_opid;
      bus.if_id_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed scoreboard bench for if_stage: stimulus pushes hand-computed expectations,
// a monitor pops and compares them against imem_addr and the IF/ID register.
module tb_if_stage;

  localparam logic [31:0] I_ADDI  = 32'h91000421;
  localparam logic [31:0] I_SUBS  = 32'hEB020020;
  localparam logic [31:0] I_LDUR  = 32'hF8408020;
  localparam logic [31:0] I_BR    = 32'hD61F03C0;
  localparam logic [31:0] I_BCOND = 32'h54000040;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] ifpc;
    logic [3:0]  opid;
    logic        valid;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [1:0]  br_taken;
  logic        uncond_br;
  logic [18:0] imm19;
  logic [25:0] imm26;
  logic [63:0] br_pc;
  logic [63:0] br_reg_data;

  int total = 0;
  int bad   = 0;
  exp_t sb_q[$];
  event sample_ev;

  if_stage_if #(.PC_W(64)) bus ();

  if_stage #(.PC_W(64), .RESET_PC(64'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .br_taken    (br_taken),
    .uncond_br   (uncond_br),
    .imm19       (imm19),
    .imm26       (imm26),
    .br_pc       (br_pc),
    .br_reg_data (br_reg_data),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic checkField(input string nm, input string fld, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField(e.name, "imem_addr", bus.imem_addr, e.pc);
    checkField(e.name, "instr", {32'h0, bus.if_id_instr}, {32'h0, e.instr});
    checkField(e.name, "if_id_pc", bus.if_id_pc, e.ifpc);
    checkField(e.name, "opid", {60'h0, bus.if_id_opid}, {60'h0, e.opid});
    checkField(e.name, "valid", {63'h0, bus.if_id_valid}, {63'h0, e.valid});
  endtask

  // Monitor: compares whenever an expectation is pending, on the inactive edge or on demand.
  initial begin
    forever begin
      @(negedge clk or sample_ev);
      while (sb_q.size() > 0) checkOutput(sb_q.pop_front());
    end
  end

  task automatic pushExp(input logic [63:0] e_pc, input logic [31:0] e_instr, input logic [63:0] e_ifpc,
                         input logic [3:0] e_opid, input logic e_valid, input string nm);
    exp_t e;
    e.pc = e_pc; e.instr = e_instr; e.ifpc = e_ifpc; e.opid = e_opid; e.valid = e_valid; e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic st, input logic fl, input logic [1:0] br, input logic un,
                               input logic [18:0] i19, input logic [25:0] i26, input logic [63:0] bpc,
                               input logic [63:0] breg, input logic [31:0] rd,
                               input logic [63:0] e_pc, input logic [31:0] e_instr, input logic [63:0] e_ifpc,
                               input logic [3:0] e_opid, input logic e_valid, input string nm);
    stall = st; flush = fl; br_taken = br; uncond_br = un;
    imm19 = i19; imm26 = i26; br_pc = bpc; br_reg_data = breg; bus.imem_rdata = rd;
    @(posedge clk);
    #1;
    pushExp(e_pc, e_instr, e_ifpc, e_opid, e_valid, nm);
  endtask

  task automatic load(input logic [31:0] rd, input logic [63:0] e_pc, input logic [63:0] e_ifpc,
                      input logic [3:0] e_opid, input string nm);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 19'h0, 26'h0, 64'h0, 64'h0, rd, e_pc, rd, e_ifpc, e_opid, 1'b1, nm);
  endtask

  task automatic jumpReg(input logic [63:0] target, input logic st, input logic fl, input string nm);
    applyStimulus(st, fl, 2'b10, 1'b0, 19'h0, 26'h0, 64'h0, target, I_ADDI, target, 32'h0, 64'h0, 4'hF, 1'b0, nm);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 2'b00; uncond_br = 1'b0;
    imm19 = '0; imm26 = '0; br_pc = '0; br_reg_data = '0; bus.imem_rdata = I_ADDI;
    #2;
    pushExp(64'h0, 32'h0, 64'h0, 4'hF, 1'b0, "reset");
    @(negedge clk);
    reset = 1'b0;

    load(I_ADDI, 64'h4,  64'h0, 4'h0, "t1_seq0");
    load(I_ADDI, 64'h8,  64'h4, 4'h0, "t1_seq1");
    load(I_ADDI, 64'hC,  64'h8, 4'h0, "t1_seq2");
    load(I_ADDI, 64'h10, 64'hC, 4'h0, "t1_seq3");

    applyStimulus(1'b0, 1'b0, 2'b01, 1'b1, 19'h10, 26'h3FFFFFE, 64'h40, 64'h0, I_ADDI,
                  64'h38, 32'h0, 64'h0, 4'hF, 1'b0, "t2_b_neg");
    load(I_SUBS, 64'h3C, 64'h38, 4'h9, "t2_subs");

    applyStimulus(1'b0, 1'b0, 2'b01, 1'b0, 19'h10, 26'h100, 64'h100, 64'h0, I_ADDI,
                  64'h140, 32'h0, 64'h0, 4'hF, 1'b0, "t3_rel19");
    applyStimulus(1'b0, 1'b0, 2'b01, 1'b0, 19'h7FFFF, 26'h10, 64'h200, 64'h0, I_ADDI,
                  64'h1FC, 32'h0, 64'h0, 4'hF, 1'b0, "t3_rel19_neg");
    jumpReg(64'h1234, 1'b0, 1'b0, "t3_br");
    load(I_LDUR, 64'h1238, 64'h1234, 4'h7, "t3_ldur");

    jumpReg(64'h1C, 1'b0, 1'b0, "t4_setup");
    load(I_BR, 64'h20, 64'h1C, 4'h5, "t4_br_load");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 19'h0, 26'h0, 64'h0, 64'h0, I_ADDI,
                    64'h20, I_BR, 64'h1C, 4'h5, 1'b1, "t4_stall");
    jumpReg(64'h80, 1'b1, 1'b0, "t4_stall_redirect");
    load(I_ADDI, 64'h84, 64'h80, 4'h0, "t4_load");
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 19'h0, 26'h0, 64'h0, 64'h0, I_ADDI,
                  64'h84, 32'h0, 64'h0, 4'hF, 1'b0, "t4_stall_flush");
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 19'h0, 26'h0, 64'h0, 64'h0, I_ADDI,
                  64'h88, 32'h0, 64'h0, 4'hF, 1'b0, "t4_flush");

    jumpReg(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, "t5_setup");
    load(32'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 4'hF, "t5_wrap");
    applyStimulus(1'b0, 1'b0, 2'b11, 1'b0, 19'h0, 26'h0, 64'h0, 64'h500, I_SUBS,
                  64'h4, I_SUBS, 64'h0, 4'h9, 1'b1, "t5_br11");
    load(I_BCOND, 64'h8, 64'h4, 4'h2, "t5_bcond");

    jumpReg(64'h44, 1'b0, 1'b0, "t6_setup");
    load(I_ADDI, 64'h48, 64'h44, 4'h0, "t6_pre");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    pushExp(64'h0, 32'h0, 64'h0, 4'hF, 1'b0, "t6_async_reset");
    ->sample_ev;
    @(negedge clk);
    reset = 1'b0;
    load(I_ADDI, 64'h4, 64'h0, 4'h0, "t6_after");

    repeat (2) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
